// File: rtl/pipelined_cla_addsub.sv
// Pipelined carry-lookahead adder/subtractor: one K-bit lookahead group resolved per stage,
// group carry registered between stages, valid/ready flow control with a single global advance.
module pipelined_cla_addsub #(
  parameter int unsigned N = 8,
  parameter int unsigned K = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] num1,
  input  logic [N-1:0] num2,
  input  logic         sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N:0]   result,
  output logic         overflow
);

  localparam int unsigned S = N / K;

  if ((N % K) != 0) begin : g_param_check
    $error("pipelined_cla_addsub: N must be a multiple of K");
  end

  logic adv;

  // Per-stage inputs. x carries the unconsumed A groups in its low bits and the
  // already-resolved sum groups in its high bits, so the word is always fully used.
  logic [N-1:0] x_st [S];
  logic [N-1:0] b_st [S];
  logic         c_st [S];
  logic         v_st [S];

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  assign x_st[0] = num1;
  assign b_st[0] = num2 ^ {N{sub}};
  assign c_st[0] = sub;
  assign v_st[0] = in_valid;

  for (genvar s = 0; s < S; s++) begin : g_stage
    logic [K-1:0] ga;
    logic [K-1:0] gb;
    logic [K-1:0] gg;
    logic [K-1:0] gp;
    logic [K-1:0] gsum;
    logic [K:0]   gc;

    assign ga = x_st[s][K-1:0];
    assign gb = b_st[s][K-1:0];
    assign gg = ga & gb;
    assign gp = ga ^ gb;

    // Flattened lookahead: every carry is a sum of products of g/p and the group carry-in.
    always_comb begin
      logic acc;
      logic pp;
      gc    = '0;
      acc   = 1'b0;
      pp    = 1'b0;
      gc[0] = c_st[s];
      for (int i = 0; i < int'(K); i++) begin
        acc = gg[i];
        pp  = gp[i];
        for (int j = i - 1; j >= 0; j--) begin
          acc = acc | (pp & gg[j]);
          pp  = pp & gp[j];
        end
        gc[i+1] = acc | (pp & c_st[s]);
      end
    end

    assign gsum = gp ^ gc[K-1:0];

    if (s < S - 1) begin : g_mid
      logic [N-1:0] x_q;
      logic [N-1:0] b_q;
      logic         c_q;
      logic         v_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          x_q <= '0;
          b_q <= '0;
          c_q <= 1'b0;
          v_q <= 1'b0;
        end else if (adv) begin
          x_q <= N'({gsum, x_st[s]} >> K);
          b_q <= b_st[s] >> K;
          c_q <= gc[K];
          v_q <= v_st[s];
        end
      end

      assign x_st[s+1] = x_q;
      assign b_st[s+1] = b_q;
      assign c_st[s+1] = c_q;
      assign v_st[s+1] = v_q;
    end else begin : g_last
      // Final stage writes straight into the output registers.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          result    <= '0;
          overflow  <= 1'b0;
          out_valid <= 1'b0;
        end else if (adv) begin
          result    <= {gc[K], N'({gsum, x_st[s]} >> K)};
          overflow  <= gc[K] ^ gc[K-1];
          out_valid <= v_st[s];
        end
      end
    end
  end

endmodule

// File: tb/tb_pipelined_cla_addsub.sv
// Self-checking bench for pipelined_cla_addsub: directed corner cases plus randomized streams
// checked against an integer-arithmetic reference model and an in-order expected queue.
module tb_pipelined_cla_addsub;

  localparam int unsigned N = 8;
  localparam int unsigned K = 4;
  localparam int unsigned S = N / K;

  typedef struct packed {
    logic [N:0] res;
    logic       ovf;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [N-1:0] num1 = '0;
  logic [N-1:0] num2 = '0;
  logic         sub = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [N:0]   result;
  logic         overflow;

  int   n_vec = 0;
  int   n_err = 0;
  int   n_out = 0;
  exp_t q[$];

  logic       last_ov;
  logic [N:0] last_res;
  logic       last_ovf;

  pipelined_cla_addsub #(.N(N), .K(K)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .num1      (num1),
    .num2      (num2),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  // Reference: plain integer arithmetic on the unsigned and signed interpretations.
  function automatic exp_t model(input logic [N-1:0] a, input logic [N-1:0] b, input logic s);
    exp_t e;
    int   ua;
    int   ub;
    int   us;
    int   sa;
    int   sb;
    int   ss;
    logic carry;
    ua = int'(a);
    ub = int'(b);
    sa = int'($signed(a));
    sb = int'($signed(b));
    us = s ? ua - ub : ua + ub;
    ss = s ? sa - sb : sa + sb;
    carry = s ? (ua >= ub) : (us >= (2 ** N));
    e.res = {carry, N'(us)};
    e.ovf = (ss > (2 ** (N - 1)) - 1) || (ss < -(2 ** (N - 1)));
    return e;
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    assert (got === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock: sample handshakes at the falling edge, then advance past the rising edge.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    last_ov  = out_valid;
    last_res = result;
    last_ovf = overflow;
    if (out_valid && out_ready) begin
      if (q.size() == 0) begin
        check("spurious_out_valid", 64'(out_valid), 64'd0);
      end else begin
        e = q.pop_front();
        check("result", 64'(result), 64'(e.res));
        check("overflow", 64'(overflow), 64'(e.ovf));
        n_out++;
      end
    end
    if (in_valid && in_ready) q.push_back(model(num1, num2, sub));
    @(posedge clk);
    #1;
  endtask

  task automatic directed(input string tag, input logic [N-1:0] a, input logic [N-1:0] b,
                          input logic s, input logic [N:0] er, input logic eo);
    int lat;
    num1      = a;
    num2      = b;
    sub       = s;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    lat = 0;
    do begin
      tick();
      lat++;
    end while (!last_ov && lat < 10);
    check({tag, "_latency"}, 64'(lat), 64'(S));
    check({tag, "_result"}, 64'(last_res), 64'(er));
    check({tag, "_overflow"}, 64'(last_ovf), 64'(eo));
  endtask

  initial begin
    int         acc;
    int         base;
    int         cnt;
    logic [N:0] snap;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_result", 64'(result), 64'd0);
    check("reset_overflow", 64'(overflow), 64'd0);
    check("reset_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed corner cases
    directed("add_ff_01", 8'hFF, 8'h01, 1'b0, 9'h100, 1'b0);
    directed("add_ovf", 8'h7F, 8'h01, 1'b0, 9'h080, 1'b1);
    directed("sub_ovf", 8'h80, 8'h01, 1'b1, 9'h17F, 1'b1);
    directed("sub_5_3", 8'h05, 8'h03, 1'b1, 9'h102, 1'b0);
    directed("sub_borrow", 8'h03, 8'h05, 1'b1, 9'h0FE, 1'b0);

    // Back-to-back stream, sub alternating each beat
    out_ready = 1'b1;
    base = n_out;
    for (int i = 0; i < 256 + int'(S); i++) begin
      if (i < 256) begin
        in_valid = 1'b1;
        num1     = N'($urandom);
        num2     = N'($urandom);
        sub      = i[0];
      end else begin
        in_valid = 1'b0;
      end
      tick();
    end
    check("stream_beat_count", 64'(n_out - base), 64'd256);

    // Backpressure: fill with out_ready low, stall, then drain
    out_ready = 1'b0;
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (!in_ready) break;
      in_valid = 1'b1;
      num1     = N'($urandom);
      num2     = N'($urandom);
      sub      = 1'(i);
      tick();
      cnt++;
    end
    check("fill_depth", 64'(cnt), 64'(S));
    snap = result;
    for (int i = 0; i < 5; i++) begin
      num1 = N'($urandom);
      num2 = N'($urandom);
      tick();
      check("stall_in_ready", 64'(in_ready), 64'd0);
      check("stall_out_valid", 64'(out_valid), 64'd1);
      check("stall_result_stable", 64'(result), 64'(snap));
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    acc = 0;
    for (int i = 0; i < int'(S) + 3; i++) begin
      tick();
      if (i < int'(S)) acc += int'(last_ov);
      else check("drain_no_duplicate", 64'(last_ov), 64'd0);
    end
    check("drain_consecutive", 64'(acc), 64'(S));
    check("drain_queue_empty", 64'(q.size()), 64'd0);

    // Reset with two beats in flight
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1;
      num1     = N'($urandom);
      num2     = N'($urandom);
      sub      = 1'(i);
      tick();
    end
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("midreset_out_valid", 64'(out_valid), 64'd0);
    check("midreset_result", 64'(result), 64'd0);
    check("midreset_overflow", 64'(overflow), 64'd0);
    q.delete();
    @(posedge clk);
    #1;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("postreset_no_stale", 64'(last_ov), 64'd0);
    end
    directed("postreset_add", 8'h12, 8'h34, 1'b0, 9'h046, 1'b0);

    // Random valid/ready traffic
    for (int i = 0; i < 400; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      num1      = N'($urandom);
      num2      = N'($urandom);
      sub       = 1'($urandom);
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (S + 2) tick();
    check("random_queue_empty", 64'(q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
